playback_ctrl: RTL and testbench

Sequencer between the sample FIFO and the modulator. It withholds samples until the FIFO holds a prefill level, then passes the modulator's read requests through. It detects underruns, rebuffers after a sustained empty FIFO, and drains remaining samples on host stop. It sits in the top level between the FIFO read port and the modulator FIFO interface, so the FT245 burst timing never starves a running transmission.

---
 rtl/playback_ctrl.sv | 156 +++++++++++++++
 tb/tb_playback_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/playback_ctrl.sv
// playback_ctrl: gates the modulator's reads from the sample FIFO.
// Waits for a prefill level, passes reads through, rebuffers after a
// sustained empty FIFO, and drains the remaining samples on host stop.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   run          host play enable (level)
//   fifo_level   FIFO occupancy, DEPTH_WIDTH+1 bits
//   fifo_empty   FIFO empty flag
//   fifo_rd_en   FIFO read strobe (combinational)
//   mod_read     modulator read request
//   mod_empty    empty flag shown to the modulator (combinational)
//   mod_enable   modulator enable (registered)
//   state        IDLE=0 PREFILL=1 PLAY=2 DRAIN=3
//   underrun     one-cycle pulse, one cycle after an underrun
//   underrun_cnt saturating underrun count
//   sample_cnt   wrapping count of delivered samples
//
// Build option: define PLAYBACK_STATS_EN to implement the two
// statistics counters; otherwise they are removed and read as 0.
`timescale 1ns/1ps

module playback_ctrl #(
   parameter int unsigned DEPTH_WIDTH   = 8,
   parameter int unsigned START_LEVEL   = 128,
   parameter int unsigned EMPTY_TIMEOUT = 1024,
   parameter int unsigned CNT_WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic [DEPTH_WIDTH:0] fifo_level,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   input  logic                 mod_read,
   output logic                 mod_empty,
   output logic                 mod_enable,
   output logic [1:0]           state,
   output logic                 underrun,
   output logic [CNT_WIDTH-1:0] underrun_cnt,
   output logic [CNT_WIDTH-1:0] sample_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PREFILL = 2'd1,
      PLAY    = 2'd2,
      DRAIN   = 2'd3
   } st_t;

   localparam int unsigned TW = $clog2(EMPTY_TIMEOUT) + 1;

   localparam logic [DEPTH_WIDTH:0] START_LVL =
      (DEPTH_WIDTH+1)'(START_LEVEL);
   localparam logic [TW-1:0] TMR_LAST =
      TW'(EMPTY_TIMEOUT - 1);

   st_t           st_q;
   logic [TW-1:0] tmr_q;
   logic          active;
   logic          und_hit;
   logic          level_ok;
   logic          tmr_done;

   // PLAY and DRAIN are the only states that hand samples out.
   assign active = (st_q == PLAY) || (st_q == DRAIN);

   assign fifo_rd_en = mod_read & active & ~fifo_empty;
   assign mod_empty  = ~active | fifo_empty;
   assign state      = st_q;

   // An empty FIFO in DRAIN is the normal end of stream, not an underrun.
   assign und_hit  = (st_q == PLAY) & mod_read & fifo_empty;
   assign level_ok = fifo_level >= START_LVL;
   assign tmr_done = tmr_q == TMR_LAST;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q       <= IDLE;
         mod_enable <= 1'b0;
         tmr_q      <= '0;
         underrun   <= 1'b0;
      end else begin
         underrun <= und_hit;
         unique case (st_q)
            IDLE: begin
               tmr_q <= '0;
               if (run) begin
                  st_q       <= PREFILL;
                  mod_enable <= 1'b0;
               end
            end
            PREFILL: begin
               tmr_q <= '0;
               if (!run) begin
                  st_q       <= IDLE;
                  mod_enable <= 1'b0;
               end else if (level_ok) begin
                  st_q       <= PLAY;
                  mod_enable <= 1'b1;
               end
            end
            PLAY: begin
               if (!run) begin
                  st_q       <= DRAIN;
                  mod_enable <= 1'b1;
                  tmr_q      <= '0;
               end else if (fifo_empty && tmr_done) begin
                  st_q       <= PREFILL;
                  mod_enable <= 1'b0;
                  tmr_q      <= '0;
               end else if (fifo_empty) begin
                  tmr_q <= tmr_q + 1'b1;
               end else begin
                  tmr_q <= '0;
               end
            end
            DRAIN: begin
               tmr_q <= '0;
               if (run) begin
                  st_q       <= PLAY;
                  mod_enable <= 1'b1;
               end else if (fifo_empty) begin
                  st_q       <= IDLE;
                  mod_enable <= 1'b0;
               end
            end
         endcase
      end
   end

`ifdef PLAYBACK_STATS_EN
   logic [CNT_WIDTH-1:0] und_cnt_q;
   logic [CNT_WIDTH-1:0] smp_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         und_cnt_q <= '0;
         smp_cnt_q <= '0;
      end else begin
         if (und_hit && (und_cnt_q != '1))
            und_cnt_q <= und_cnt_q + 1'b1;
         if (fifo_rd_en)
            smp_cnt_q <= smp_cnt_q + 1'b1;
      end
   end

   assign underrun_cnt = und_cnt_q;
   assign sample_cnt   = smp_cnt_q;
`else
   assign underrun_cnt = '0;
   assign sample_cnt   = '0;
`endif

endmodule

// File: tb/tb_playback_ctrl.sv
// tb_playback_ctrl: random and directed stimulus for playback_ctrl,
// scoreboarded against a cycle-level behavioural model.
`timescale 1ns/1ps

module tb_playback_ctrl;

   localparam int DW   = 8;
   localparam int SL   = 128;
   localparam int TO   = 1024;
   localparam int CW   = 16;
   localparam int CW2  = 2;

   localparam int S_IDLE    = 0;
   localparam int S_PREFILL = 1;
   localparam int S_PLAY    = 2;
   localparam int S_DRAIN   = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          run = 1'b0;
   logic [DW:0]   fifo_level = '0;
   logic          fifo_empty = 1'b1;
   logic          mod_read = 1'b0;
   logic          fifo_rd_en, mod_empty, mod_enable, underrun;
   logic [1:0]    state;
   logic [CW-1:0] underrun_cnt, sample_cnt;

   logic           rd_en2, mempty2, menable2, und2;
   logic [1:0]     state2;
   logic [CW2-1:0] ucnt2, scnt2;

   always #5 clk = ~clk;

   playback_ctrl #(
      .DEPTH_WIDTH(DW), .START_LEVEL(SL),
      .EMPTY_TIMEOUT(TO), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst), .run(run),
      .fifo_level(fifo_level), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .mod_read(mod_read),
      .mod_empty(mod_empty), .mod_enable(mod_enable),
      .state(state), .underrun(underrun),
      .underrun_cnt(underrun_cnt), .sample_cnt(sample_cnt)
   );

   // Narrow-counter copy on the same stimulus, for saturation/wrap.
   playback_ctrl #(
      .DEPTH_WIDTH(DW), .START_LEVEL(SL),
      .EMPTY_TIMEOUT(TO), .CNT_WIDTH(CW2)
   ) dut2 (
      .clk(clk), .rst(rst), .run(run),
      .fifo_level(fifo_level), .fifo_empty(fifo_empty),
      .fifo_rd_en(rd_en2), .mod_read(mod_read),
      .mod_empty(mempty2), .mod_enable(menable2),
      .state(state2), .underrun(und2),
      .underrun_cnt(ucnt2), .sample_cnt(scnt2)
   );

   typedef struct {
      int st;
      int en;
      int und;
      int rd;
      int me;
      int uc;
      int sc;
      int uc2;
      int sc2;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Behavioural model state.
   int m_st;
   int m_und;
   int m_empty_run;
   int n_und;
   int n_smp;

   task automatic chk(input string n, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", n, cyc, got, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("state", int'(state), e.st);
         chk("mod_enable", int'(mod_enable), e.en);
         chk("underrun", int'(underrun), e.und);
         chk("fifo_rd_en", int'(fifo_rd_en), e.rd);
         chk("mod_empty", int'(mod_empty), e.me);
         chk("underrun_cnt", int'(underrun_cnt), e.uc);
         chk("sample_cnt", int'(sample_cnt), e.sc);
         chk("underrun_cnt_w2", int'(ucnt2), e.uc2);
         chk("sample_cnt_w2", int'(scnt2), e.sc2);
         chk("state_w2", int'(state2), e.st);
         chk("fifo_rd_en_w2", int'(rd_en2), e.rd);
      end
   end

   task automatic m_reset();
      m_st        = S_IDLE;
      m_und       = 0;
      m_empty_run = 0;
      n_und       = 0;
      n_smp       = 0;
   endtask

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   // One clock of stimulus: drive inputs, push the expected view of
   // this cycle, then advance the model across the next edge.
   task automatic cycle(input bit r, input int lvl, input bit emp,
                        input bit rd, input bit rn);
      exp_t e;
      bit   playing;
      bit   served;
      int   nxt;
      @(posedge clk);
      #1;
      cyc++;
      run        = r;
      fifo_level = (DW+1)'(lvl);
      fifo_empty = emp;
      mod_read   = rd;
      if (!rn) begin
         rst = 1'b0;
         #1;
         m_reset();
      end else begin
         rst = 1'b1;
      end
      playing = (m_st == S_PLAY) || (m_st == S_DRAIN);
      served  = rd && playing && !emp;
      e.st  = m_st;
      e.en  = playing ? 1 : 0;
      e.und = m_und;
      e.rd  = served ? 1 : 0;
      e.me  = (!playing || emp) ? 1 : 0;
`ifdef PLAYBACK_STATS_EN
      e.uc  = sat(n_und, CW);
      e.sc  = n_smp % (1 << CW);
      e.uc2 = sat(n_und, CW2);
      e.sc2 = n_smp % (1 << CW2);
`else
      e.uc  = 0;
      e.sc  = 0;
      e.uc2 = 0;
      e.sc2 = 0;
`endif
      exp_q.push_back(e);
      if (rn) begin
         m_und = (m_st == S_PLAY && rd && emp) ? 1 : 0;
         n_und += m_und;
         if (served) n_smp++;
         nxt = m_st;
         case (m_st)
            S_IDLE:    if (r) nxt = S_PREFILL;
            S_PREFILL: begin
               if (!r) nxt = S_IDLE;
               else if (lvl >= SL) nxt = S_PLAY;
            end
            S_PLAY: begin
               if (!r) nxt = S_DRAIN;
               else if (emp && m_empty_run + 1 >= TO) nxt = S_PREFILL;
            end
            default: begin
               if (r) nxt = S_PLAY;
               else if (emp) nxt = S_IDLE;
            end
         endcase
         if (m_st == S_PLAY && nxt == S_PLAY && emp)
            m_empty_run++;
         else
            m_empty_run = 0;
         m_st = nxt;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bit r;
      bit emp;
      int lvl;
      m_reset();
      repeat (3) cycle(0, 0, 1, 0, 0);
      repeat (3) cycle(0, 0, 1, 0, 1);
      // Level one short of the start threshold: no reads leak through.
      repeat (6) cycle(1, SL - 1, 0, 1, 1);
      repeat (3) cycle(1, SL, 0, 0, 1);
      for (int i = 0; i < 20; i++) cycle(1, 100, 0, i % 2, 1);
      for (int i = 0; i < 6; i++) cycle(1, 0, 1, i % 2, 1);
      // Sustained empty in PLAY forces a rebuffer.
      repeat (TO + 10) cycle(1, 0, 1, 0, 1);
      repeat (3) cycle(1, 200, 0, 0, 1);
      // Host stop: drain five samples, then finish on empty.
      repeat (5) cycle(0, 5, 0, 1, 1);
      repeat (3) cycle(0, 0, 1, 1, 1);
      r = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 49) == 0) r = ~r;
         emp = ($urandom_range(0, 3) == 0);
         lvl = emp ? 0 : int'($urandom_range(1, 1 << DW));
         cycle(r, lvl, emp, 1'($urandom_range(0, 1)), 1);
      end
      repeat (4) cycle(1, 200, 0, 0, 1);
      // Reset mid-stream with a read pending.
      cycle(1, 200, 0, 1, 0);
      repeat (2) cycle(1, 200, 0, 1, 0);
      repeat (4) cycle(0, 0, 1, 0, 1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
